// File: rtl/qei_pkg.sv
// Shared constants for the quadrature encoder interface: phase encodings,
// step classification and the default counter width.
package qei_pkg;

    localparam int CNT_W_DEF = 16;

    // Gray-coded quadrature phases in forward order, written as {A,B}
    localparam logic [1:0] PH_0 = 2'b00;
    localparam logic [1:0] PH_1 = 2'b01;
    localparam logic [1:0] PH_2 = 2'b11;
    localparam logic [1:0] PH_3 = 2'b10;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_FWD  = 2'd1,
        STEP_BWD  = 2'd2,
        STEP_ILL  = 2'd3
    } step_t;

    function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
        step_t step;
        case ({prev, cur})
            {PH_0, PH_1}, {PH_1, PH_2}, {PH_2, PH_3}, {PH_3, PH_0}: step = STEP_FWD;
            {PH_0, PH_3}, {PH_3, PH_2}, {PH_2, PH_1}, {PH_1, PH_0}: step = STEP_BWD;
            {PH_0, PH_0}, {PH_1, PH_1}, {PH_2, PH_2}, {PH_3, PH_3}: step = STEP_NONE;
            default:                                                step = STEP_ILL;
        endcase
        return step;
    endfunction

endpackage

// File: rtl/qei_sync.sv
// Multi-flop synchronizer for one asynchronous input bit; clears on reset.
module qei_sync
    import qei_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_reg <= '0;
        end else begin
            chain_reg <= {chain_reg[STAGES-2:0], d};
        end
    end

    assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/tt_um_jakedrew_qei.sv
// Quadrature encoder decoder: synchronizes A/B/clear, decodes Gray-code steps
// and maintains a wrapping position counter with a direction flag.
module tt_um_jakedrew_qei
    import qei_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [2:0]       raw_in;
    logic [2:0]       sync_out;
    logic [1:0]       ab_cur;
    logic             clr_sync;
    logic [1:0]       prev_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             dir_reg;
    logic             dir_next;
    step_t            step;

    // Bit order: 0 = A, 1 = B, 2 = clear
    assign raw_in = ui_in[2:0];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            qei_sync #(.STAGES(SYNC_STAGES)) u_sync (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (raw_in[gi]),
                .q     (sync_out[gi])
            );
        end
    endgenerate

    assign ab_cur   = {sync_out[0], sync_out[1]};
    assign clr_sync = sync_out[2];
    assign step     = decode_step(prev_reg, ab_cur);

    always_comb begin
        count_next = count_reg;
        dir_next   = dir_reg;
        if (clr_sync) begin
            count_next = '0;
        end else if (step == STEP_FWD) begin
            count_next = count_reg + 1'b1;
            dir_next   = 1'b1;
        end else if (step == STEP_BWD) begin
            count_next = count_reg - 1'b1;
            dir_next   = 1'b0;
        end
    end

    // Previous phase tracks every sample, including illegal jumps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_reg  <= 2'b00;
            count_reg <= '0;
            dir_reg   <= 1'b0;
        end else begin
            prev_reg  <= ab_cur;
            count_reg <= count_next;
            dir_reg   <= dir_next;
        end
    end

    assign uo_out  = {dir_reg, count_reg[6:0]};
    assign uio_out = count_reg[15:8];
    assign uio_oe  = 8'hFF;

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:3], count_reg[7]};

endmodule

// File: tb/tb_tt_um_jakedrew_qei.sv
// Self-checking bench: directed boundary cases plus randomized encoder motion
// compared against a phase-index arithmetic model of position and direction.
module tb_tt_um_jakedrew_qei;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks_cnt = 0;
    int errors_cnt = 0;

    logic [15:0] m_cnt;
    logic        m_dir;
    logic [1:0]  m_prev;

    tt_um_jakedrew_qei dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Position of a phase along the forward cycle 00,01,11,10
    function automatic int phase_pos(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_move(input logic [1:0] ab);
        int d;
        d = (phase_pos(ab) - phase_pos(m_prev) + 4) % 4;
        if (d == 1) begin
            m_cnt = m_cnt + 16'd1;
            m_dir = 1'b1;
        end else if (d == 3) begin
            m_cnt = m_cnt - 16'd1;
            m_dir = 1'b0;
        end
        m_prev = ab;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] ab, input logic clr);
        ui_in = {5'b0, clr, ab[0], ab[1]};
    endtask

    task automatic check_state(input string tag);
        check({tag, "_lo"},  {25'b0, uo_out[6:0]}, {25'b0, m_cnt[6:0]});
        check({tag, "_hi"},  {24'b0, uio_out},     {24'b0, m_cnt[15:8]});
        check({tag, "_dir"}, {31'b0, uo_out[7]},   {31'b0, m_dir});
    endtask

    task automatic step_to(input logic [1:0] ab, input int hold);
        drive(ab, 1'b0);
        model_move(ab);
        cycles(hold);
    endtask

    task automatic clear_pulse(input int width);
        drive(m_prev, 1'b1);
        cycles(width);
        drive(m_prev, 1'b0);
        m_cnt = 16'd0;
        cycles(6);
    endtask

    task automatic fwd_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            step_to(2'b01, 4); step_to(2'b11, 4); step_to(2'b10, 4); step_to(2'b00, 4);
        end
    endtask

    task automatic bwd_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            step_to(2'b10, 4); step_to(2'b11, 4); step_to(2'b01, 4); step_to(2'b00, 4);
        end
    endtask

    initial begin
        logic [1:0]  fseq [4];
        logic [1:0]  bseq [4];
        logic [15:0] start_cnt;
        logic [6:0]  lo_before;
        logic [7:0]  hi_before;
        fseq = '{2'b01, 2'b11, 2'b10, 2'b00};
        bseq = '{2'b10, 2'b11, 2'b01, 2'b00};

        ena    = 1'b1;
        uio_in = 8'h00;
        ui_in  = 8'h00;
        rst_n  = 1'b0;
        m_cnt  = 16'd0;
        m_dir  = 1'b0;
        m_prev = 2'b00;
        cycles(3);
        rst_n = 1'b1;
        cycles(16);
        check("reset_uo",  {24'b0, uo_out},  32'h00);
        check("reset_uio", {24'b0, uio_out}, 32'h00);
        check("reset_oe",  {24'b0, uio_oe},  32'hFF);

        start_cnt = m_cnt;
        for (int i = 0; i < 4; i++) begin
            step_to(fseq[i], 8);
            check_state("fwd_step");
            $display("fwd step to %b: count=%0h dir=%0b", fseq[i], m_cnt, m_dir);
        end
        for (int i = 0; i < 4; i++) begin
            step_to(bseq[i], 8);
            check_state("bwd_step");
            $display("bwd step to %b: count=%0h dir=%0b", bseq[i], m_cnt, m_dir);
        end
        check("back_to_start", {25'b0, uo_out[6:0]}, {25'b0, start_cnt[6:0]});

        lo_before = uo_out[6:0];
        fwd_cycles(8);
        check("fwd8_delta", {25'b0, uo_out[6:0] - lo_before}, 32'd32);
        check_state("fwd8");
        hi_before = uio_out;
        fwd_cycles(64);
        check("fwd64_hi_delta", {24'b0, uio_out - hi_before}, 32'd1);
        check_state("fwd64");
        hi_before = uio_out;
        bwd_cycles(64);
        check("bwd64_hi_delta", {24'b0, hi_before - uio_out}, 32'd1);
        check_state("bwd64");

        clear_pulse(4);
        check_state("clear");
        step_to(2'b10, 8);
        check("wrap_under_lo", {25'b0, uo_out[6:0]}, 32'h7F);
        check("wrap_under_hi", {24'b0, uio_out}, 32'hFF);
        check_state("wrap_under");
        step_to(2'b00, 8);
        check("wrap_over", {24'b0, uio_out, uo_out[6:0]} & 32'h7FFF, 32'h0000);
        check_state("wrap_over");

        step_to(2'b01, 8);
        step_to(2'b11, 8);
        step_to(2'b10, 8);
        step_to(2'b01, 8);  // illegal jump 10 -> 01
        check_state("illegal");
        step_to(2'b00, 8);
        step_to(2'b11, 8);  // illegal jump 00 -> 11
        check_state("illegal_00_11");
        clear_pulse(4);
        check_state("clear_pulse");

        for (int n = 0; n < 150; n++) begin
            logic [1:0] ab;
            bit         clr;
            int         hold;
            ab   = 2'($urandom_range(0, 3));
            clr  = ($urandom_range(0, 9) == 0);
            hold = $urandom_range(4, 8);
            if (clr) begin
                drive(ab, 1'b1);
                m_prev = ab;
                m_cnt  = 16'd0;
                cycles(6);
                drive(ab, 1'b0);
                cycles(4);
            end else begin
                step_to(ab, hold);
            end
            $display("rand %0d: ab=%b clr=%0b hold=%0d count=%0h dir=%0b", n, ab, clr, hold, m_cnt, m_dir);
            check_state("rand");
        end

        fwd_cycles(2);
        step_to(2'b01, 4);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_uo",  {24'b0, uo_out},  32'h00);
        check("async_rst_uio", {24'b0, uio_out}, 32'h00);
        check("async_rst_oe",  {24'b0, uio_oe},  32'hFF);
        m_cnt  = 16'd0;
        m_dir  = 1'b0;
        m_prev = 2'b00;
        drive(2'b11, 1'b0);
        cycles(3);
        rst_n = 1'b1;
        model_move(2'b11);
        cycles(8);
        check_state("release_11");
        step_to(2'b10, 8);
        check_state("after_release");

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
